// File: rtl/mem_stage.sv
// mem_stage: pipeline memory stage with an IDLE/ACCESS bus FSM, store lane packing,
// load lane extraction/extension and misalignment exceptions.
module mem_stage #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int EX_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] PC_in,
    input  logic              pipeline_in_valid,
    input  logic [EX_W-1:0]   exception_in,
    input  logic              exception_in_valid,
    input  logic [1:0]        mem_op,
    input  logic [2:0]        funct,
    input  logic [DATA_W-1:0] result_in,
    input  logic [DATA_W-1:0] store_data,
    input  logic [4:0]        rd_addr_in,
    input  logic              rd_wr_en_in,
    input  logic              flush,
    output logic              stall,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic              dmem_rd_enable,
    output logic              dmem_wr_enable,
    output logic [DATA_W-1:0] dmem_wr_data,
    output logic [3:0]        dmem_wr_mask,
    input  logic [DATA_W-1:0] dmem_rd_data,
    input  logic              dmem_ready,
    output logic              pipeline_out_valid,
    output logic [ADDR_W-1:0] PC_out,
    output logic [4:0]        rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_wr_en,
    output logic [EX_W-1:0]   exception_out,
    output logic              exception_out_valid
);
    typedef enum logic {IDLE, ACCESS} state_t;
    state_t state, state_nx;
    logic kill, wen_q;
    logic [2:0] funct_q;
    logic [1:0] off_q;
    logic [4:0] rd_q;
    logic [ADDR_W-1:0] pc_q, addr;
    logic [DATA_W-1:0] res_q, shifted, load_val, wr_data;
    logic [3:0] wr_mask;
    logic accept, is_mem, byte_op, half_op, misal, go_mem, retire_now, done, drop;

    assign stall = (state == ACCESS);
    assign addr = ADDR_W'(result_in);

    always_comb begin
        accept     = (state == IDLE) && pipeline_in_valid && !flush;
        is_mem     = mem_op[0] ^ mem_op[1];
        byte_op    = (funct[1:0] == 2'b00);
        half_op    = (funct[1:0] == 2'b01);
        misal      = half_op ? result_in[0] : (!byte_op && result_in[1:0] != 2'b00);
        go_mem     = accept && !exception_in_valid && is_mem && !misal;
        retire_now = accept && !go_mem;
        done       = (state == ACCESS) && dmem_ready;
        drop       = kill || flush;
        state_nx   = go_mem ? ACCESS : done ? IDLE : state;
        wr_mask    = byte_op ? 4'b0001 << result_in[1:0] : half_op ? 4'b0011 << result_in[1:0] : 4'b1111;
        wr_data    = byte_op ? DATA_W'({4{store_data[7:0]}}) : half_op ? DATA_W'({2{store_data[15:0]}}) : store_data;
        shifted    = dmem_rd_data >> {off_q, 3'b000};
        load_val   = (funct_q[1:0] == 2'b00) ? DATA_W'({{24{~funct_q[2] & shifted[7]}}, shifted[7:0]}) :
                     (funct_q[1:0] == 2'b01) ? DATA_W'({{16{~funct_q[2] & shifted[15]}}, shifted[15:0]}) :
                     dmem_rd_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            kill <= 1'b0;
            wen_q <= 1'b0;
            funct_q <= '0;
            off_q <= '0;
            rd_q <= '0;
            pc_q <= '0;
            res_q <= '0;
            dmem_addr <= '0;
            dmem_rd_enable <= 1'b0;
            dmem_wr_enable <= 1'b0;
            dmem_wr_data <= '0;
            dmem_wr_mask <= '0;
            pipeline_out_valid <= 1'b0;
            PC_out <= '0;
            rd_addr <= '0;
            rd_data <= '0;
            rd_wr_en <= 1'b0;
            exception_out <= '0;
            exception_out_valid <= 1'b0;
        end else begin
            state <= state_nx;
            pipeline_out_valid <= 1'b0;
            rd_wr_en <= 1'b0;
            exception_out_valid <= 1'b0;
            // Non-memory, upstream-exception and misaligned ops retire straight from IDLE
            if (retire_now) begin
                pipeline_out_valid <= 1'b1;
                PC_out <= PC_in;
                rd_addr <= rd_addr_in;
                rd_data <= result_in;
                rd_wr_en <= (is_mem && !exception_in_valid) ? 1'b0 : rd_wr_en_in;
                exception_out <= (is_mem && !exception_in_valid) ? EX_W'(mem_op[0] ? 4 : 6) : exception_in;
                exception_out_valid <= exception_in_valid || is_mem;
            end
            if (go_mem) begin
                dmem_addr <= {addr[ADDR_W-1:2], 2'b00};
                dmem_rd_enable <= mem_op[0];
                dmem_wr_enable <= mem_op[1];
                dmem_wr_data <= wr_data;
                dmem_wr_mask <= wr_mask;
                pc_q <= PC_in;
                rd_q <= rd_addr_in;
                wen_q <= rd_wr_en_in;
                funct_q <= funct;
                off_q <= result_in[1:0];
                res_q <= result_in;
                kill <= 1'b0;
            end
            if (state == ACCESS && flush)
                kill <= 1'b1;
            // A flushed transaction still completes on the bus; only its result is dropped
            if (done) begin
                dmem_rd_enable <= 1'b0;
                dmem_wr_enable <= 1'b0;
                kill <= 1'b0;
                pipeline_out_valid <= !drop;
                PC_out <= pc_q;
                rd_addr <= rd_q;
                rd_data <= dmem_rd_enable ? load_val : res_q;
                rd_wr_en <= dmem_rd_enable && wen_q && !drop;
                exception_out <= '0;
            end
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized and directed checks of mem_stage against a byte-level memory model.
module tb_mem_stage;
    logic clk = 1'b0, reset = 1'b0;
    logic [31:0] PC_in = '0, result_in = '0, store_data = '0, dmem_rd_data = '0;
    logic pipeline_in_valid = 1'b0, exception_in_valid = 1'b0, rd_wr_en_in = 1'b0, flush = 1'b0, dmem_ready = 1'b0;
    logic [3:0] exception_in = '0;
    logic [1:0] mem_op = '0;
    logic [2:0] funct = '0;
    logic [4:0] rd_addr_in = '0;
    logic stall, dmem_rd_enable, dmem_wr_enable, pipeline_out_valid, rd_wr_en, exception_out_valid;
    logic [31:0] dmem_addr, dmem_wr_data, PC_out, rd_data;
    logic [3:0] dmem_wr_mask, exception_out;
    logic [4:0] rd_addr;
    int n_chk = 0, n_fail = 0;
    logic [31:0] mem [0:255];

    mem_stage dut (
        .clk(clk), .reset(reset), .PC_in(PC_in), .pipeline_in_valid(pipeline_in_valid),
        .exception_in(exception_in), .exception_in_valid(exception_in_valid), .mem_op(mem_op),
        .funct(funct), .result_in(result_in), .store_data(store_data), .rd_addr_in(rd_addr_in),
        .rd_wr_en_in(rd_wr_en_in), .flush(flush), .stall(stall), .dmem_addr(dmem_addr),
        .dmem_rd_enable(dmem_rd_enable), .dmem_wr_enable(dmem_wr_enable), .dmem_wr_data(dmem_wr_data),
        .dmem_wr_mask(dmem_wr_mask), .dmem_rd_data(dmem_rd_data), .dmem_ready(dmem_ready),
        .pipeline_out_valid(pipeline_out_valid), .PC_out(PC_out), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_wr_en(rd_wr_en), .exception_out(exception_out), .exception_out_valid(exception_out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_valid"}, 32'(pipeline_out_valid), 0);
        check({tag, "_wen"}, 32'(rd_wr_en), 0);
        check({tag, "_stall"}, 32'(stall), 0);
        check({tag, "_en"}, 32'({dmem_rd_enable, dmem_wr_enable}), 0);
    endtask

    task automatic idle();
        dmem_ready = 1'($urandom_range(0, 1));
        flush = 1'($urandom_range(0, 1));
        dmem_rd_data = $urandom;
        step();
        dmem_ready = 1'b0;
        flush = 1'b0;
        check_quiet("idle");
    endtask

    task automatic do_op(input logic [31:0] pc, input logic [31:0] addr, input logic [31:0] sd,
                         input logic [1:0] op, input logic [2:0] f, input logic exv, input logic [3:0] ex,
                         input logic [4:0] rd, input logic wen, input int lat, input bit fl);
        int sz = (f[1:0] == 2'b00) ? 1 : (f[1:0] == 2'b01) ? 2 : 4;
        int off = int'(addr % 4);
        int bits = sz * 8;
        bit is_mem = (op == 2'd1) || (op == 2'd2);
        bit touch = is_mem && !exv && (addr % sz == 0);
        logic [31:0] w, v, wd;
        logic [3:0] m;
        logic [7:0] idx = addr[9:2];
        wd = (sz == 1) ? {24'b0, sd[7:0]} * 32'h01010101 : (sz == 2) ? {16'b0, sd[15:0]} * 32'h00010001 : sd;
        m = 4'(((1 << sz) - 1) << off);
        PC_in = pc; result_in = addr; store_data = sd; mem_op = op; funct = f;
        exception_in_valid = exv; exception_in = ex; rd_addr_in = rd; rd_wr_en_in = wen;
        pipeline_in_valid = 1'b1;
        step();
        pipeline_in_valid = 1'b0; exception_in_valid = 1'b0; mem_op = 2'($urandom);
        result_in = $urandom; store_data = $urandom;
        if (!touch) begin
            check("imm_valid", 32'(pipeline_out_valid), 1);
            check("imm_pc", PC_out, pc);
            check("imm_rd", 32'(rd_addr), 32'(rd));
            check("imm_data", rd_data, addr);
            check("imm_wen", 32'(rd_wr_en), 32'((is_mem && !exv) ? 1'b0 : wen));
            check("imm_exv", 32'(exception_out_valid), 32'(exv || is_mem));
            if (exv) check("imm_exc", 32'(exception_out), 32'(ex));
            else if (is_mem) check("imm_exc", 32'(exception_out), (op == 2'd1) ? 4 : 6);
            check("imm_stall", 32'(stall), 0);
            check("imm_en", 32'({dmem_rd_enable, dmem_wr_enable}), 0);
            return;
        end
        for (int i = 0; i <= lat; i++) begin
            if (i > 0) begin
                dmem_ready = 1'b0;
                dmem_rd_data = $urandom;
                flush = fl && (i == 1);
                step();
                flush = 1'b0;
            end
            check("acc_stall", 32'(stall), 1);
            check("acc_addr", dmem_addr, addr & ~32'd3);
            check("acc_en", 32'({dmem_rd_enable, dmem_wr_enable}), (op == 2'd1) ? 2 : 1);
            check("acc_valid", 32'(pipeline_out_valid), 0);
            if (op == 2'd2) begin
                check("acc_mask", 32'(dmem_wr_mask), 32'(m));
                check("acc_wdata", dmem_wr_data, wd);
            end
        end
        dmem_ready = 1'b1;
        dmem_rd_data = mem[idx];
        step();
        dmem_ready = 1'b0;
        check("done_valid", 32'(pipeline_out_valid), 32'(!fl));
        check("done_stall", 32'(stall), 0);
        check("done_en", 32'({dmem_rd_enable, dmem_wr_enable}), 0);
        if (op == 2'd1) begin
            w = mem[idx] >> (off * 8);
            v = (sz == 4) ? w : w & ((32'd1 << bits) - 1);
            if (sz < 4 && !f[2] && v >= (32'd1 << (bits - 1))) v = v - (32'd1 << bits);
            check("done_wen", 32'(rd_wr_en), 32'(wen && !fl));
            if (!fl) begin
                check("load_data", rd_data, v);
                check("load_pc", PC_out, pc);
                check("load_rd", 32'(rd_addr), 32'(rd));
            end
        end else begin
            check("store_wen", 32'(rd_wr_en), 0);
            for (int b = 0; b < 4; b++)
                if (m[b]) mem[idx][8*b +: 8] = wd[8*b +: 8];
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] f;
        logic [31:0] a;
        int lat;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        step();
        step();
        check("rst_valid", 32'(pipeline_out_valid), 0);
        check("rst_stall", 32'(stall), 0);
        check("rst_en", 32'({dmem_rd_enable, dmem_wr_enable}), 0);
        check("rst_pc", PC_out, 0);
        check("rst_data", rd_data, 0);
        check("rst_exv", 32'(exception_out_valid), 0);
        reset = 1'b1;
        step();
        do_op(32'h40, 32'h1234, 0, 2'd0, 3'd2, 0, 0, 5'd5, 1, 0, 0);
        idle();
        mem[8'h40] = 32'h80FF7F01;
        do_op(32'h44, 32'h103, 0, 2'd1, 3'd0, 0, 0, 5'd7, 1, 1, 0);
        do_op(32'h48, 32'h103, 0, 2'd1, 3'd4, 0, 0, 5'd8, 1, 0, 0);
        do_op(32'h4C, 32'h202, 32'h0000BEEF, 2'd2, 3'd1, 0, 0, 5'd0, 0, 3, 0);
        do_op(32'h50, 32'h101, 0, 2'd1, 3'd2, 0, 0, 5'd9, 1, 0, 0);
        do_op(32'h54, 32'h102, 0, 2'd2, 3'd2, 0, 0, 5'd0, 0, 0, 0);
        do_op(32'h58, 32'h100, 0, 2'd1, 3'd2, 0, 0, 5'd3, 1, 2, 1);
        do_op(32'h5C, 32'h100, 0, 2'd1, 3'd2, 1, 4'd2, 5'd3, 1, 0, 0);
        idle();
        PC_in = 32'h60; result_in = 32'h100; mem_op = 2'd1; funct = 3'd2;
        pipeline_in_valid = 1'b1; flush = 1'b1;
        step();
        pipeline_in_valid = 1'b0; flush = 1'b0;
        check_quiet("iflush");
        step();
        check_quiet("iflush2");
        PC_in = 32'h64; result_in = 32'h104; mem_op = 2'd1; funct = 3'd2; pipeline_in_valid = 1'b1;
        step();
        pipeline_in_valid = 1'b0;
        check("pre_rst_stall", 32'(stall), 1);
        reset = 1'b0;
        #1;
        check_quiet("arst");
        check("arst_addr", dmem_addr, 0);
        check("arst_pc", PC_out, 0);
        check("arst_data", rd_data, 0);
        check("arst_exv", 32'(exception_out_valid), 0);
        #2;
        reset = 1'b1;
        step();
        do_op(32'h68, 32'h104, 0, 2'd1, 3'd2, 0, 0, 5'd4, 1, 1, 0);
        for (int n = 0; n < 200; n++) begin
            f = 3'($urandom);
            a = $urandom_range(0, 1023);
            if ($urandom_range(0, 1) == 1) a = a & ~32'((f[1:0] == 2'b00) ? 0 : (f[1:0] == 2'b01) ? 1 : 3);
            lat = $urandom_range(0, 3);
            do_op($urandom, a, $urandom, 2'($urandom), f, 1'($urandom_range(0, 7) == 0), 4'($urandom),
                  5'($urandom), 1'($urandom), lat, lat > 0 && $urandom_range(0, 5) == 0);
            if ($urandom_range(0, 2) == 0) idle();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter ADDR_W, 32, address width.
REQ-002 SHALL have parameter DATA_W, 32, data and register width.
REQ-003 SHALL have parameter EX_W, 4, exception code width.
REQ-004 clk  in  1  sole clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset (reset==0 resets immediately).
REQ-006 PC_in  in  ADDR_W  PC of instruction from execute.
REQ-007 pipeline_in_valid  in  1  input instruction valid.
REQ-008 exception_in  in  EX_W, and exception_in_valid  in  1: upstream exception.
REQ-009 mem_op  in  2  00 none, 01 load, 10 store, 11 reserved (treated as none).
REQ-010 funct  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU; other values behave as W.
REQ-011 result_in  in  DATA_W  ALU result; effective address for loads/stores.
REQ-012 store_data  in  DATA_W; rd_addr_in  in  5; rd_wr_en_in  in  1.
REQ-013 flush  in  1  discard the current instruction in this stage.
REQ-014 stall  out  1  upstream hold; inputs are not accepted while high.
REQ-015 dmem_addr  out  ADDR_W (word-aligned, [1:0]=00); dmem_rd_enable, dmem_wr_enable  out  1.
REQ-016 dmem_wr_data  out  DATA_W; dmem_wr_mask  out  4; dmem_rd_data  in  DATA_W; dmem_ready  in  1.
REQ-017 Outputs to writeback: pipeline_out_valid 1, PC_out ADDR_W, rd_addr 5, rd_data DATA_W, rd_wr_en 1, exception_out EX_W, exception_out_valid 1.

Function
REQ-018 FSM states are IDLE and ACCESS; stall SHALL equal (state==ACCESS).
REQ-019 In IDLE, an instruction is accepted when pipeline_in_valid==1 and flush==0.
REQ-020 When the accepted instruction has exception_in_valid=1 or mem_op none, it SHALL NOT touch memory and SHALL appear on the outputs next cycle, with rd_data=result_in and other fields passed through (latency 1).
REQ-021 A load with addr[0]!=0 for H/HU, or addr[1:0]!=0 for W, SHALL raise exception code 4, and a misaligned store SHALL raise code 6; either case gives latency 1, rd_wr_en=0, and no memory access.
REQ-022 An aligned load or store SHALL move to ACCESS; from the next cycle, dmem_*_enable, dmem_addr, wr_data and mask SHALL be held stable until dmem_ready==1 is sampled.
REQ-023 Store mask: B gives 0001<<addr[1:0]; H gives 0011<<addr[1:0]; W gives 1111. Store data is replicated across lanes (byte x4, half x2).
REQ-024 Load data: select the byte or half by addr[1:0], then sign-extend for B/H or zero-extend for BU/HU; a store forces rd_wr_en=0.
REQ-025 On dmem_ready in ACCESS, the FSM SHALL return to IDLE, with outputs valid next cycle, enables deasserted next cycle, and no new acceptance in that same cycle.
REQ-026 pipeline_out_valid SHALL be a one-cycle pulse per retired instruction; in cycles with no retirement it is 0 and rd_wr_en is 0.
REQ-027 Flush in IDLE SHALL block acceptance and force pipeline_out_valid=0 next cycle.
REQ-028 Flush in ACCESS SHALL NOT abort the bus transaction; it sets a kill flag, the transaction completes, the result is dropped (pipeline_out_valid=0), and the flag clears on return to IDLE.
REQ-029 dmem_ready outside ACCESS SHALL be ignored.

Reset
REQ-030 reset==0 SHALL put the FSM in IDLE and clear the kill flag, immediately and asynchronously.
REQ-031 The same reset SHALL drive every output to 0.
REQ-032 Reset during ACCESS SHALL drop the request immediately (enables=0) with no output produced.

Verification
REQ-033 A non-memory op with result_in=0x1234, rd=5 SHALL give pipeline_out_valid=1, rd_data=0x1234, rd_wr_en=1 one cycle later, with stall never asserted.
REQ-034 LB at 0x103 with mem word 0x80FF7F01 SHALL give rd_data=0xFFFFFF80; LBU at the same address SHALL give 0x00000080; dmem_addr is 0x100 in both cases.
REQ-035 SH of 0x0000BEEF at 0x202 SHALL give mask=1100 and wr_data=0xBEEFBEEF; with dmem_ready delayed 3 cycles, stall is high for 4 cycles and rd_wr_en=0.
REQ-036 LW at 0x101 SHALL give exception_out_valid=1, exception_out=4, no dmem enable, and latency 1.
REQ-037 LW in ACCESS, flush pulsed and ready 2 cycles later SHALL keep the transaction held until ready, with pipeline_out_valid staying 0.
REQ-038 reset low mid-ACCESS SHALL set all outputs to 0 at once; after release, a new instruction is accepted normally.
